ren_binner: RTL and testbench

- Binning stage directly downstream of triangle setup.
- Accepts one set-up triangle per handshake: integer tile-space bounding box plus triangle ID.
- Clips the box to the screen and walks it tile by tile in row-major order.
- For each tile, appends the triangle ID to that tile's bin in external bin memory and maintains the per-tile entry counts that the rasteriser reads back.

---
 rtl/ren_binner_if.sv | 32 +++
 rtl/ren_binner.sv | 98 +++++++++
 tb/tb_ren_binner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ren_binner_if.sv
// ren_binner_if: setup handshake, bin-memory write port and count readback of the binner
interface ren_binner_if #(
  parameter int TRI_ID_W = 12,
  parameter int ADDR_W   = 15,
  parameter int CNT_W    = 7,
  parameter int RD_W     = 9
);
  logic                i_valid;
  logic                o_busy;
  logic [15:0]         i_tile_x;
  logic [15:0]         i_tile_y;
  logic [15:0]         i_steps_x;
  logic [15:0]         i_steps_y;
  logic [TRI_ID_W-1:0] i_tri_id;
  logic                i_clear;
  logic                o_wr_en;
  logic [ADDR_W-1:0]   o_wr_addr;
  logic [TRI_ID_W-1:0] o_wr_data;
  logic                i_wr_ready;
  logic [RD_W-1:0]     i_rd_tile;
  logic [CNT_W-1:0]    o_rd_cnt;
  logic                o_overflow;
  logic                o_idle;
  modport slave (
    input  i_valid, i_tile_x, i_tile_y, i_steps_x, i_steps_y, i_tri_id, i_clear, i_wr_ready, i_rd_tile,
    output o_busy, o_wr_en, o_wr_addr, o_wr_data, o_rd_cnt, o_overflow, o_idle
  );
  modport master (
    output i_valid, i_tile_x, i_tile_y, i_steps_x, i_steps_y, i_tri_id, i_clear, i_wr_ready, i_rd_tile,
    input  o_busy, o_wr_en, o_wr_addr, o_wr_data, o_rd_cnt, o_overflow, o_idle
  );
endinterface

// File: rtl/ren_binner.sv
// ren_binner: clips a triangle's tile bounding box to the screen and appends its ID to every covered tile bin
module ren_binner #(
  parameter int TILES_X     = 20,
  parameter int TILES_Y     = 15,
  parameter int MAX_PER_BIN = 64,
  parameter int TRI_ID_W    = 12,
  parameter int CNT_W       = $clog2(MAX_PER_BIN) + 1,
  parameter int ADDR_W      = $clog2(TILES_X * TILES_Y * MAX_PER_BIN)
) (
  input logic       clk,
  input logic       rstn,
  ren_binner_if.slave bus
);
  localparam int N     = TILES_X * TILES_Y;
  localparam int IDX_W = $clog2(N);
  localparam int X_W   = $clog2(TILES_X);
  localparam int Y_W   = $clog2(TILES_Y);
  localparam logic signed [17:0] X_MAX = 18'(TILES_X - 1);
  localparam logic signed [17:0] Y_MAX = 18'(TILES_Y - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, WALK} state_t;
  state_t                state, state_d;
  logic [X_W-1:0]        cx, x_lo, x_hi;
  logic [Y_W-1:0]        cy, y_hi;
  logic [IDX_W-1:0]      clr_idx, tile_idx;
  logic [TRI_ID_W-1:0]   tri_id;
  logic [CNT_W-1:0]      cnt [N];
  logic [CNT_W-1:0]      cur_cnt;
  logic                  overflow, full, advance, last, accept, empty;
  logic signed [17:0]    xa, xe, ya, ye, xl, xh, yl, yh;
  // 18-bit signed keeps tile+steps from wrapping for any 16-bit inputs
  always_comb begin
    xa    = 18'(signed'(bus.i_tile_x));
    ya    = 18'(signed'(bus.i_tile_y));
    xe    = xa + 18'(bus.i_steps_x);
    ye    = ya + 18'(bus.i_steps_y);
    xl    = xa < 0 ? 18'sd0 : xa;
    yl    = ya < 0 ? 18'sd0 : ya;
    xh    = xe > X_MAX ? X_MAX : xe;
    yh    = ye > Y_MAX ? Y_MAX : ye;
    empty = (xl > xh) | (yl > yh);
  end
  assign tile_idx = IDX_W'(cy) * IDX_W'(TILES_X) + IDX_W'(cx);
  assign cur_cnt  = cnt[tile_idx];
  assign full     = cur_cnt == CNT_W'(MAX_PER_BIN);
  assign last     = (cx == x_hi) & (cy == y_hi);
  assign advance  = (state == WALK) & (full | bus.i_wr_ready);
  assign accept   = (state == IDLE) & bus.i_valid & ~bus.i_clear;
  assign bus.o_busy     = (state != IDLE) | bus.i_clear;
  assign bus.o_idle     = state == IDLE;
  assign bus.o_wr_en    = (state == WALK) & ~full;
  assign bus.o_wr_addr  = ADDR_W'({tile_idx, cur_cnt[CNT_W-2:0]});
  assign bus.o_wr_data  = tri_id;
  assign bus.o_overflow = overflow;
  assign bus.o_rd_cnt   = ({1'b0, bus.i_rd_tile} < (IDX_W+1)'(N)) ? cnt[bus.i_rd_tile] : '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    state_d = state == IDLE  ? (bus.i_clear ? CLEAR : (bus.i_valid & ~empty) ? WALK : IDLE) :
              state == CLEAR ? (clr_idx == IDX_W'(N - 1) ? IDLE : CLEAR) :
              (advance & last) ? IDLE : WALK;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cx       <= '0;
      cy       <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      y_hi     <= '0;
      clr_idx  <= '0;
      tri_id   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      if (accept) begin
        cx     <= xl[X_W-1:0];
        cy     <= yl[Y_W-1:0];
        x_lo   <= xl[X_W-1:0];
        x_hi   <= xh[X_W-1:0];
        y_hi   <= yh[Y_W-1:0];
        tri_id <= bus.i_tri_id;
      end
      if (state == IDLE && bus.i_clear) clr_idx <= '0;
      if (state == CLEAR) begin
        cnt[clr_idx] <= '0;
        clr_idx      <= clr_idx + 1'b1;
        overflow     <= 1'b0;
      end
      if (state == WALK && full) overflow <= 1'b1;
      if (bus.o_wr_en && bus.i_wr_ready) cnt[tile_idx] <= cur_cnt + 1'b1;
      if (advance) begin
        cx <= cx == x_hi ? x_lo : cx + 1'b1;
        cy <= cx == x_hi ? cy + 1'b1 : cy;
      end
    end
  end
endmodule

// File: tb/tb_ren_binner.sv
// tb_ren_binner: directed and random triangles checked against a tile-list/bin-count reference model
module tb_ren_binner;
  localparam int TX = 20, TY = 15, NT = TX * TY, MAXB = 64;
  logic clk, rstn;
  int checks = 0, errors = 0;
  int cnt_m [NT];
  bit ovf_m;
  ren_binner_if bus();
  ren_binner dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tri(input int tx, input int ty, input int sx, input int sy, input int id,
                         input int stall_first, input bit rnd);
    int q[$];
    int n;
    int xl = tx < 0 ? 0 : tx;
    int yl = ty < 0 ? 0 : ty;
    int xh = tx + sx > TX - 1 ? TX - 1 : tx + sx;
    int yh = ty + sy > TY - 1 ? TY - 1 : ty + sy;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) q.push_back(y * TX + x);
    bus.i_valid = 1'b1; bus.i_tile_x = 16'(tx); bus.i_tile_y = 16'(ty);
    bus.i_steps_x = 16'(sx); bus.i_steps_y = 16'(sy); bus.i_tri_id = 12'(id);
    #1;
    chk("accept_busy", bus.o_busy, 0);
    tick();
    bus.i_valid = 1'b0; bus.i_tile_x = 16'($urandom); bus.i_tile_y = 16'($urandom);
    bus.i_steps_x = 16'($urandom); bus.i_tri_id = 12'($urandom);
    for (int i = 0; i < q.size(); i++) begin
      bus.i_rd_tile = 9'(q[i]);
      if (cnt_m[q[i]] >= MAXB) begin
        bus.i_wr_ready = 1'($urandom);
        #1;
        chk("drop_wr_en", bus.o_wr_en, 0);
        tick();
        ovf_m = 1'b1;
        continue;
      end
      n = i == 0 ? stall_first : (rnd ? $urandom_range(0, 2) : 0);
      for (int k = 0; k < n; k++) begin
        bus.i_wr_ready = 1'b0;
        #1;
        chk("stall_wr_en", bus.o_wr_en, 1);
        chk("stall_addr", bus.o_wr_addr, q[i] * MAXB + cnt_m[q[i]]);
        chk("stall_data", bus.o_wr_data, id);
        chk("stall_cnt", bus.o_rd_cnt, cnt_m[q[i]]);
        tick();
      end
      bus.i_wr_ready = 1'b1;
      #1;
      chk("wr_en", bus.o_wr_en, 1);
      chk("wr_addr", bus.o_wr_addr, q[i] * MAXB + cnt_m[q[i]]);
      chk("wr_data", bus.o_wr_data, id);
      tick();
      cnt_m[q[i]]++;
    end
    #1;
    chk("end_idle", bus.o_idle, 1);
    chk("end_wr_en", bus.o_wr_en, 0);
    chk("end_ovf", bus.o_overflow, ovf_m);
    if (q.size() > 0) begin
      bus.i_rd_tile = 9'(q[q.size() - 1]);
      #1;
      chk("end_cnt", bus.o_rd_cnt, cnt_m[q[q.size() - 1]]);
    end
  endtask

  initial begin
    int t;
    rstn = 1'b0;
    bus.i_valid = 0; bus.i_tile_x = 0; bus.i_tile_y = 0; bus.i_steps_x = 0; bus.i_steps_y = 0;
    bus.i_tri_id = 0; bus.i_clear = 0; bus.i_wr_ready = 1; bus.i_rd_tile = 0;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    ovf_m = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    chk("rst_idle", bus.o_idle, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_wr_en", bus.o_wr_en, 0);
    chk("rst_ovf", bus.o_overflow, 0);
    chk("rst_cnt", bus.o_rd_cnt, 0);

    run_tri(2, 3, 1, 1, 5, 0, 0);
    bus.i_rd_tile = 62; #1;
    chk("cnt62", bus.o_rd_cnt, 1);
    run_tri(-1, 14, 2, 3, 7, 0, 0);
    bus.i_rd_tile = 281; #1;
    chk("cnt281", bus.o_rd_cnt, 1);
    run_tri(20, 3, 0, 0, 9, 0, 0);
    chk("offscreen_busy", bus.o_busy, 0);

    for (int i = 0; i < 65; i++) run_tri(0, 0, 0, 0, i, 0, 0);
    bus.i_rd_tile = 0; #1;
    chk("full_cnt0", bus.o_rd_cnt, 64);
    chk("full_ovf", bus.o_overflow, 1);
    bus.i_clear = 1'b1; #1;
    chk("clear_busy_req", bus.o_busy, 1);
    tick();
    bus.i_clear = 1'b0;
    for (int k = 0; k < NT; k++) begin
      chk("clear_busy", bus.o_busy, 1);
      tick();
    end
    chk("clear_done_idle", bus.o_idle, 1);
    chk("clear_done_busy", bus.o_busy, 0);
    chk("clear_ovf", bus.o_overflow, 0);
    for (int i = 0; i < NT; i++) begin
      bus.i_rd_tile = 9'(i); #1;
      chk("cleared_cnt", bus.o_rd_cnt, 0);
      cnt_m[i] = 0;
    end
    ovf_m = 0;

    run_tri(7, 2, 0, 0, 21, 5, 0);

    bus.i_valid = 1; bus.i_tile_x = 5; bus.i_tile_y = 5; bus.i_steps_x = 3; bus.i_steps_y = 3;
    bus.i_tri_id = 11; bus.i_wr_ready = 1;
    tick();
    bus.i_valid = 0;
    repeat (3) tick();
    bus.i_rd_tile = 105; #1;
    chk("walk_cnt105", bus.o_rd_cnt, 1);
    chk("walk_wr_en", bus.o_wr_en, 1);
    rstn = 1'b0; #1;
    chk("async_wr_en", bus.o_wr_en, 0);
    chk("async_idle", bus.o_idle, 1);
    chk("async_cnt105", bus.o_rd_cnt, 0);
    foreach (cnt_m[i]) cnt_m[i] = 0;
    ovf_m = 0;
    tick();
    rstn = 1'b1;
    tick();
    chk("rel_idle", bus.o_idle, 1);

    bus.i_clear = 1; bus.i_valid = 1; bus.i_tile_x = 0; bus.i_tile_y = 0;
    bus.i_steps_x = 0; bus.i_steps_y = 0; bus.i_tri_id = 3; #1;
    chk("clrvld_busy", bus.o_busy, 1);
    tick();
    bus.i_clear = 0; bus.i_valid = 0;
    chk("clrvld_not_idle", bus.o_idle, 0);
    chk("clrvld_wr_en", bus.o_wr_en, 0);
    repeat (NT) tick();
    bus.i_rd_tile = 0; #1;
    chk("clrvld_idle", bus.o_idle, 1);
    chk("clrvld_cnt0", bus.o_rd_cnt, 0);

    for (int i = 0; i < 40; i++)
      run_tri($urandom_range(0, 27) - 5, $urandom_range(0, 20) - 4,
              $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4095),
              $urandom_range(0, 2), 1);
    for (int i = 0; i < 20; i++) begin
      t = $urandom_range(0, NT - 1);
      bus.i_rd_tile = 9'(t); #1;
      chk("rand_cnt", bus.o_rd_cnt, cnt_m[t]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
